// File: rtl/uart_rx_if.sv
// uart_rx_if -- serial line and receive-result bundle for uart_rx.
//
// Signals:
//   RxD           serial line (8N1, idle high, LSB first)
//   data[7:0]     last correctly framed byte
//   valid         one-cycle pulse, data updated
//   framing_error one-cycle pulse, stop bit sampled low
//   busy          receiver not idle
//
// Modports:
//   master  line driver / result consumer (drives RxD)
//   slave   receiver (drives data, valid, framing_error, busy)
interface uart_rx_if;
  logic       RxD;
  logic [7:0] data;
  logic       valid;
  logic       framing_error;
  logic       busy;

  modport master (
    output RxD,
    input  data,
    input  valid,
    input  framing_error,
    input  busy
  );

  modport slave (
    input  RxD,
    output data,
    output valid,
    output framing_error,
    output busy
  );
endinterface

// File: rtl/uart_rx.sv
// uart_rx -- 8N1 UART receiver with mid-bit sampling.
//
// Ports:
//   clk    system clock, all state on rising edge
//   reset  asynchronous active-low reset
//   rx     uart_rx_if.slave: RxD in; data, valid, framing_error, busy out
//
// Parameter:
//   CLKS_PER_BIT  clk cycles per bit, 8..16383 (default 100 MHz / 9600 baud)
//
// Build option:
//   UART_RX_MAJORITY_EN  when defined, each sample is the 2-of-3 majority of
//                        the synchronized line at terminal-2, terminal-1 and
//                        terminal count; otherwise the single value at the
//                        terminal count is used. Latency is identical.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | line idle, waiting for a falling edge
// START | timing to mid start bit, confirming it is still low
// DATA  | sampling 8 data bits at mid-bit, LSB first
// STOP  | sampling the stop bit at mid-bit
// BREAK | stop bit was low; wait for the line to return high
module uart_rx #(
  parameter int CLKS_PER_BIT = 10416
) (
  input  logic     clk,
  input  logic     reset,
  uart_rx_if.slave rx
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } state_t;

  localparam logic [13:0] C_BIT_LAST  = 14'(CLKS_PER_BIT - 1);
  localparam logic [13:0] C_HALF_LAST = 14'(CLKS_PER_BIT / 2 - 1);

  state_t      r_state;
  logic [13:0] r_cnt;
  logic [2:0]  r_bit;
  logic [7:0]  r_shift;
  logic [7:0]  r_data;
  logic        r_valid;
  logic        r_ferr;
  logic        r_busy;
  logic [1:0]  r_sync;
  logic        w_rxd_s;
  logic        w_sample;

  // Two-flop synchronizer; resets to the idle (high) line level so a reset
  // release never looks like a start edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_sync <= 2'b11;
    else        r_sync <= {r_sync[0], rx.RxD};
  end

  assign w_rxd_s = r_sync[1];

`ifdef UART_RX_MAJORITY_EN
  // r_hist[1] holds rxd_s from two cycles ago, r_hist[0] from one cycle ago,
  // so at a terminal count the three votes are terminal-2, -1 and terminal.
  logic [1:0] r_hist;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_hist <= 2'b11;
    else        r_hist <= {r_hist[0], w_rxd_s};
  end

  assign w_sample = (r_hist[1] & r_hist[0]) |
                    (r_hist[1] & w_rxd_s)   |
                    (r_hist[0] & w_rxd_s);
`else
  assign w_sample = w_rxd_s;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_data  <= 8'h00;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      case (r_state)
        IDLE: begin
          r_cnt <= '0;
          r_bit <= '0;
          if (!w_rxd_s) begin
            r_state <= START;
            r_busy  <= 1'b1;
          end
        end

        START: begin
          if (r_cnt == C_HALF_LAST) begin
            r_cnt <= '0;
            r_bit <= '0;
            if (!w_sample) begin
              r_state <= DATA;
            end else begin
              // Start bit gone high by mid-bit: treat as a glitch.
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt + 14'd1;
          end
        end

        DATA: begin
          if (r_cnt == C_BIT_LAST) begin
            r_cnt   <= '0;
            r_shift <= {w_sample, r_shift[7:1]};
            r_bit   <= r_bit + 3'd1;
            if (r_bit == 3'd7) r_state <= STOP;
          end else begin
            r_cnt <= r_cnt + 14'd1;
          end
        end

        STOP: begin
          if (r_cnt == C_BIT_LAST) begin
            r_cnt <= '0;
            // Leaving at mid-stop-bit leaves half a bit of margin to catch
            // a back-to-back start edge.
            if (w_sample) begin
              r_data  <= r_shift;
              r_valid <= 1'b1;
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_ferr  <= 1'b1;
              r_state <= BREAK;
            end
          end else begin
            r_cnt <= r_cnt + 14'd1;
          end
        end

        BREAK: begin
          r_cnt <= '0;
          if (w_rxd_s) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end

        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
          r_bit   <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign rx.data          = r_data;
  assign rx.valid         = r_valid;
  assign rx.framing_error = r_ferr;
  assign rx.busy          = r_busy;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx -- directed bench for uart_rx with CLKS_PER_BIT = 16.
// RxD is driven on falling clock edges; outputs are observed on falling edges.
module tb_uart_rx;
  localparam int CPB = 16;

  logic clk = 1'b0;
  logic reset;

  uart_rx_if bus ();

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk   (clk),
    .reset (reset),
    .rx    (bus)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         n_valid = 0;
  int         n_ferr = 0;
  int         t_valid = 0;
  int         t_start = 0;
  bit         both_hi = 1'b0;
  bit         data_glitch = 1'b0;
  logic [7:0] prev_data = 8'h00;
  logic [7:0] log_q[$];

  // Output monitor: counts cycles each pulse is high and logs received bytes.
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (bus.valid === 1'b1) begin
      n_valid++;
      t_valid = cyc;
      log_q.push_back(bus.data);
    end
    if (bus.framing_error === 1'b1) n_ferr++;
    if (bus.valid === 1'b1 && bus.framing_error === 1'b1) both_hi = 1'b1;
    if (reset === 1'b1 && bus.valid !== 1'b1 && bus.data !== prev_data)
      data_glitch = 1'b1;
    prev_data = bus.data;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input int n);
    bus.RxD = v;
    repeat (n) @(negedge clk);
  endtask

  // glitch_bit >= 0 inverts that data bit for the single cycle captured at
  // its mid-bit sample point.
  task automatic send_frame(input logic [7:0] b, input logic stop_v,
                            input int stop_len, input int glitch_bit);
    t_start = cyc;
    drive(1'b0, CPB);
    for (int i = 0; i < 8; i++) begin
      if (i == glitch_bit) begin
        drive(b[i], CPB / 2);
        drive(~b[i], 1);
        drive(b[i], CPB / 2 - 1);
      end else begin
        drive(b[i], CPB);
      end
    end
    drive(stop_v, stop_len);
  endtask

  int v0, f0, k0, lat;

  initial begin
    bus.RxD = 1'b1;
    reset   = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_data",  bus.data, 8'h00);
    check("rst_valid", bus.valid, 1'b0);
    check("rst_ferr",  bus.framing_error, 1'b0);
    check("rst_busy",  bus.busy, 1'b0);
    reset = 1'b1;
    drive(1'b1, 10);

    // Clean frame 0xA5
    v0 = n_valid; f0 = n_ferr;
    send_frame(8'hA5, 1'b1, CPB, -1);
    drive(1'b1, 20);
    check("a5_valid_cnt", n_valid - v0, 1);
    check("a5_data",      bus.data, 8'hA5);
    check("a5_ferr_cnt",  n_ferr - f0, 0);
    check("a5_busy",      bus.busy, 1'b0);
    lat = t_valid - t_start;
    check("a5_latency_154_156", (lat >= 154 && lat <= 156), 1'b1);

    // Short low pulse: start rejected
    v0 = n_valid; f0 = n_ferr;
    drive(1'b0, 5);
    check("glitch_busy_during", bus.busy, 1'b1);
    drive(1'b1, 30);
    check("glitch_valid_cnt", n_valid - v0, 0);
    check("glitch_ferr_cnt",  n_ferr - f0, 0);
    check("glitch_busy_after", bus.busy, 1'b0);

    // 0x3C with low stop bit, line held low 40 cycles
    v0 = n_valid; f0 = n_ferr;
    send_frame(8'h3C, 1'b0, 40, -1);
    check("ferr_cnt",        n_ferr - f0, 1);
    check("ferr_valid_cnt",  n_valid - v0, 0);
    check("ferr_data_held",  bus.data, 8'hA5);
    check("ferr_busy_break", bus.busy, 1'b1);
    drive(1'b1, 5);
    check("ferr_busy_idle",  bus.busy, 1'b0);
    drive(1'b1, 20);

    // Back-to-back 0x00 then 0xFF, no idle between
    v0 = n_valid; k0 = log_q.size();
    send_frame(8'h00, 1'b1, CPB, -1);
    send_frame(8'hFF, 1'b1, CPB, -1);
    drive(1'b1, 40);
    check("b2b_valid_cnt", n_valid - v0, 2);
    check("b2b_first",  (log_q.size() > k0)     ? log_q[k0]     : 8'hxx, 8'h00);
    check("b2b_second", (log_q.size() > k0 + 1) ? log_q[k0 + 1] : 8'hxx, 8'hFF);
    check("b2b_data",   bus.data, 8'hFF);

    // Reset during data bit 4 of 0x55, then frame 0x81
    v0 = n_valid;
    drive(1'b0, CPB);
    for (int i = 0; i < 4; i++) drive(((8'h55 >> i) & 8'h01) != 8'h00, CPB);
    drive(1'b1, 8);
    reset = 1'b0;
    drive(1'b1, 3);
    check("midrst_data",  bus.data, 8'h00);
    check("midrst_busy",  bus.busy, 1'b0);
    check("midrst_valid", bus.valid, 1'b0);
    reset = 1'b1;
    drive(1'b1, 100);
    check("midrst_no_valid", n_valid - v0, 0);
    send_frame(8'h81, 1'b1, CPB, -1);
    drive(1'b1, 40);
    check("midrst_valid_cnt", n_valid - v0, 1);
    check("midrst_data_81",   bus.data, 8'h81);

    // 0x0F with a one-cycle inversion at mid-bit of bit 2
    v0 = n_valid;
    send_frame(8'h0F, 1'b1, CPB, 2);
    drive(1'b1, 40);
    check("maj_valid_cnt", n_valid - v0, 1);
`ifdef UART_RX_MAJORITY_EN
    check("maj_data", bus.data, 8'h0F);
`else
    check("maj_data", bus.data, 8'h0B);
`endif

    check("never_valid_and_ferr", both_hi, 1'b0);
    check("data_held_between_valid", data_glitch, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
